// File: rtl/spi_dac_tx.sv
// spi_dac_tx: 16-bit MSB-first SPI transmitter for the audio DAC, framed by active-low sync_n.
// Optional macro SPI_DAC_TX_HOLD_EN adds a one-deep hold register so frames can run back to back.
module spi_dac_tx #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic        mosi,
  output logic        sck_out,
  output logic        sync_n,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WIDTH = 16;
  localparam logic [7:0]  TERM  = 8'(DIV - 1);
  localparam logic [3:0]  LAST  = 4'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state_r, state_nxt;
  logic [7:0]       cnt_r, cnt_nxt;
  logic             tick_s;
  // Bits still to be sent after the one currently on mosi.
  logic [WIDTH-2:0] rem_r, rem_nxt;
  logic [3:0]       bit_r, bit_nxt;
  logic             phase_r, phase_nxt;
  logic             mosi_nxt, sck_nxt, sync_nxt, busy_nxt, done_nxt;

`ifdef SPI_DAC_TX_HOLD_EN
  logic [WIDTH-1:0] hold_r, hold_nxt;
  logic             pend_r, pend_nxt;
  logic [WIDTH-1:0] next_word_s;

  // A start in the final GAP cycle is newer than anything held, so it wins.
  assign next_word_s = start ? data_in : hold_r;
`endif

  assign tick_s = (cnt_r == TERM);

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_nxt = state_r;
    rem_nxt   = rem_r;
    bit_nxt   = bit_r;
    phase_nxt = phase_r;
    mosi_nxt  = mosi;
    sck_nxt   = sck_out;
    sync_nxt  = sync_n;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
`ifdef SPI_DAC_TX_HOLD_EN
    if (busy && start) begin
      hold_nxt = data_in;
      pend_nxt = 1'b1;
    end else begin
      hold_nxt = hold_r;
      pend_nxt = pend_r;
    end
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          rem_nxt   = data_in[WIDTH-2:0];
          mosi_nxt  = data_in[WIDTH-1];
          sck_nxt   = 1'b1;
          sync_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end else begin
          mosi_nxt  = 1'b0;
          sck_nxt   = 1'b1;
          sync_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      SETUP: begin
        if (tick_s) begin
          state_nxt = SHIFT;
          bit_nxt   = 4'd0;
          phase_nxt = 1'b0;
          sck_nxt   = 1'b0;
        end else begin
          state_nxt = SETUP;
        end
      end
      SHIFT: begin
        if (!tick_s) begin
          state_nxt = SHIFT;
        end else if (!phase_r) begin
          // Rising SCK: the DAC already sampled on the fall, so present the next bit.
          sck_nxt   = 1'b1;
          phase_nxt = 1'b1;
          mosi_nxt  = rem_r[WIDTH-2];
          rem_nxt   = {rem_r[WIDTH-3:0], 1'b0};
        end else if (bit_r == LAST) begin
          state_nxt = GAP;
          sync_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
        end else begin
          sck_nxt   = 1'b0;
          phase_nxt = 1'b0;
          bit_nxt   = bit_r + 4'd1;
        end
      end
      GAP: begin
        if (tick_s) begin
          done_nxt = 1'b1;
`ifdef SPI_DAC_TX_HOLD_EN
          if (start || pend_r) begin
            state_nxt = SETUP;
            rem_nxt   = next_word_s[WIDTH-2:0];
            mosi_nxt  = next_word_s[WIDTH-1];
            sck_nxt   = 1'b1;
            sync_nxt  = 1'b0;
            busy_nxt  = 1'b1;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
`else
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
`endif
        end else begin
          state_nxt = GAP;
        end
      end
      default: begin
        state_nxt = IDLE;
        mosi_nxt  = 1'b0;
        sck_nxt   = 1'b1;
        sync_nxt  = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Divider restarts on every state entry and wraps on each tick.
  always_comb begin
    if ((state_r == IDLE) || (state_nxt != state_r) || tick_s) begin
      cnt_nxt = 8'd0;
    end else begin
      cnt_nxt = cnt_r + 8'd1;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      rem_r   <= '0;
      bit_r   <= 4'd0;
      phase_r <= 1'b0;
      mosi    <= 1'b0;
      sck_out <= 1'b1;
      sync_n  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      rem_r   <= rem_nxt;
      bit_r   <= bit_nxt;
      phase_r <= phase_nxt;
      mosi    <= mosi_nxt;
      sck_out <= sck_nxt;
      sync_n  <= sync_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

`ifdef SPI_DAC_TX_HOLD_EN
  // Hold register and pending flag for a word requested mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_r <= '0;
      pend_r <= 1'b0;
    end else begin
      hold_r <= hold_nxt;
      pend_r <= pend_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_spi_dac_tx.sv
// Scoreboard bench for spi_dac_tx: two instances (DIV=4 and DIV=1), a frame-level reference
// model fills an expectation queue, and an independent monitor decodes the SPI lines.
module tb_spi_dac_tx;

  typedef struct {
    int          unit;
    logic [15:0] word;
    int          start;
    int          due;
  } frame_t;

  logic        clk;
  logic        rst;
  logic [1:0]  st;
  logic [15:0] din [2];
  logic [1:0]  mosi_w, sck_w, sync_w, busy_w, done_w;

  int     cyc;
  int     tests;
  int     fails;
  frame_t exp_q [$];
  int     divs [2];
  int     busy_end [2];
  int     pend_edge [2];
  bit     pend_valid [2];

  spi_dac_tx #(.DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(st[0]), .data_in(din[0]),
    .mosi(mosi_w[0]), .sck_out(sck_w[0]), .sync_n(sync_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  spi_dac_tx #(.DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .data_in(din[1]),
    .mosi(mosi_w[1]), .sck_out(sck_w[1]), .sync_n(sync_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int find_first(input int u);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].unit == u) return i;
    end
    return -1;
  endfunction

  function automatic int find_last(input int u);
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].unit == u) return i;
    end
    return -1;
  endfunction

  // Idle until the bench cycle counter reaches target, scrambling data_in meanwhile.
  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      din[0] = 16'($urandom);
      din[1] = 16'($urandom);
      @(negedge clk);
    end
  endtask

  // Pulse start for one cycle and update the frame-level model.
  task automatic issue(input int u, input logic [15:0] w);
    int     e;
    int     idx;
    int     d;
    frame_t f;
    d = divs[u];
    e = cyc + 1;
    din[u] = w;
    st[u]  = 1'b1;
    if (pend_valid[u] && (e <= pend_edge[u])) begin
      idx = find_last(u);
      if (idx >= 0) exp_q[idx].word = w;
    end else if (e <= busy_end[u]) begin
`ifdef SPI_DAC_TX_HOLD_EN
      f.unit  = u;
      f.word  = w;
      f.start = busy_end[u];
      f.due   = busy_end[u] + 34 * d;
      exp_q.push_back(f);
      pend_edge[u]  = busy_end[u];
      busy_end[u]   = f.due;
      pend_valid[u] = 1'b1;
`endif
    end else begin
      f.unit  = u;
      f.word  = w;
      f.start = e;
      f.due   = e + 34 * d;
      exp_q.push_back(f);
      busy_end[u]   = f.due;
      pend_valid[u] = 1'b0;
    end
    @(negedge clk);
    st[u]  = 1'b0;
    din[u] = 16'($urandom);
  endtask

  // Monitor: decode bits at falling SCK, check timing, compare the frame when done pulses.
  initial begin : monitor
    logic [1:0]  prev_sck;
    logic [15:0] acc [2];
    int          nb [2];
    int          idx;
    logic        exp_busy;
    prev_sck = 2'b11;
    for (int u = 0; u < 2; u++) begin
      acc[u] = 16'h0000;
      nb[u]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rst !== 1'b1) begin
          nb[u]       = 0;
          prev_sck[u] = 1'b1;
        end else begin
          if (prev_sck[u] && !sck_w[u]) begin
            idx = find_first(u);
            if (idx < 0) begin
              tests++;
              fails++;
              $display("FAIL sck_fall_without_frame: unit %0d fell at cycle %0d, expected no activity", u, cyc);
            end else begin
              check("sck_fall_time", cyc, exp_q[idx].start + divs[u] * (1 + 2 * nb[u]));
            end
            acc[u] = {acc[u][14:0], mosi_w[u]};
            nb[u]++;
          end
          prev_sck[u] = sck_w[u];
          if (done_w[u]) begin
            idx = find_first(u);
            if (idx < 0) begin
              tests++;
              fails++;
              $display("FAIL spurious_done: unit %0d done=1 at cycle %0d, expected no frame end", u, cyc);
            end else begin
              check("frame_word", acc[u], exp_q[idx].word);
              check("bit_count", nb[u], 16);
              check("done_time", cyc, exp_q[idx].due);
              exp_q.delete(idx);
              idx = find_first(u);
              exp_busy = 1'b0;
              if (idx >= 0) begin
                if (exp_q[idx].start == cyc) exp_busy = 1'b1;
              end
              check("busy_at_done", busy_w[u], exp_busy);
            end
            nb[u] = 0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int          e;
    int          last;
    int          u;
    bit          ok;
    logic [15:0] first_w;
    cyc    = 0;
    tests  = 0;
    fails  = 0;
    divs[0] = 4;
    divs[1] = 1;
    for (int i = 0; i < 2; i++) begin
      busy_end[i]   = 0;
      pend_edge[i]  = 0;
      pend_valid[i] = 1'b0;
      din[i]        = 16'h0000;
    end
    st  = 2'b00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_mosi", mosi_w[i], 1'b0);
      check("rst_sck", sck_w[i], 1'b1);
      check("rst_sync_n", sync_w[i], 1'b1);
      check("rst_busy", busy_w[i], 1'b0);
      check("rst_done", done_w[i], 1'b0);
    end
    rst = 1'b1;
    wait_cyc(cyc + 2);

    // Single DIV=4 frame with A5C3.
    issue(0, 16'hA5C3);
    e = cyc;
    check("t1_sync_edge0", sync_w[0], 1'b0);
    check("t1_busy_edge0", busy_w[0], 1'b1);
    check("t1_mosi_edge0", mosi_w[0], 1'b1);
    wait_cyc(e + 131);
    check("t1_sync_edge131", sync_w[0], 1'b0);
    wait_cyc(e + 132);
    check("t1_sync_edge132", sync_w[0], 1'b1);
    wait_cyc(e + 136);
    check("t1_done_edge136", done_w[0], 1'b1);
    wait_cyc(e + 137);
    check("t1_done_single", done_w[0], 1'b0);

    // DIV=1: second start coincident with done.
    issue(1, 16'hFFFF);
    e = cyc;
    wait_cyc(e + 34);
    check("t2_done", done_w[1], 1'b1);
    check("t2_busy_low_at_done", busy_w[1], 1'b0);
    issue(1, 16'h0000);
    check("t2_sync_after_done", sync_w[1], 1'b0);
    check("t2_busy_after_done", busy_w[1], 1'b1);
    wait_cyc(busy_end[1] + 2);

    // Reset mid-frame at edge 40, then a full frame.
    issue(0, 16'($urandom));
    e = cyc;
    wait_cyc(e + 40);
    rst = 1'b0;
    #1;
    check("t3_mosi", mosi_w[0], 1'b0);
    check("t3_sck", sck_w[0], 1'b1);
    check("t3_sync_n", sync_w[0], 1'b1);
    check("t3_busy", busy_w[0], 1'b0);
    check("t3_done", done_w[0], 1'b0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      busy_end[i]   = 0;
      pend_valid[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(cyc + 3);
    issue(0, 16'($urandom));
    wait_cyc(busy_end[0] + 2);

    // Starts during a busy frame: dropped, or held with last word winning.
`ifdef SPI_DAC_TX_HOLD_EN
    first_w = 16'hABCD;
`else
    first_w = 16'h8001;
`endif
    issue(0, first_w);
    e = cyc;
    wait_cyc(e + 9);
    issue(0, 16'h1234);
    wait_cyc(e + 49);
    issue(0, 16'h5678);
    last = busy_end[0];
    ok = 1'b1;
    while (cyc < last) begin
      if (busy_w[0] !== 1'b1) ok = 1'b0;
      din[0] = 16'($urandom);
      @(negedge clk);
    end
    check("t4_busy_continuous", ok, 1'b1);
    check("t4_busy_fall", busy_w[0], 1'b0);
    wait_cyc(last + 40);
    check("t4_idle_sync", sync_w[0], 1'b1);
    check("t4_no_extra_frame", find_first(0), -1);

    // Randomized traffic on both instances.
    for (int n = 0; n < 12; n++) begin
      u = int'($urandom_range(0, 1));
      issue(u, 16'($urandom));
      wait_cyc(cyc + int'($urandom_range(0, 40 * divs[u])));
    end
    wait_cyc(((busy_end[0] > busy_end[1]) ? busy_end[0] : busy_end[1]) + 5);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_dac_tx.md
# spi_dac_tx

SPI transmitter that serialises 16-bit output samples to the audio DAC, the output-side counterpart of the ADC SPI capture master. Accepts a parallel word on a single-cycle `start` strobe and shifts it out MSB-first on `mosi`. Generates `sck_out` and an active-low frame select `sync_n`. Reports progress with `busy`/`done` to the equaliser datapath.

## Interface
Parameters:
- `DIV`, default 4: SCK half-period in `clk` cycles; legal range 1..255.
- `WIDTH`, fixed 16: frame length in bits; not overridable.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request to send `data_in`; sampled on each rising `clk` edge.
- `data_in`  input  16  sample word; captured in the cycle `start` is accepted.
- `mosi`  output  1  serial data to DAC, MSB first.
- `sck_out`  output  1  serial clock; idles high.
- `sync_n`  output  1  frame select; low for the duration of a frame.
- `busy`  output  1  high while a frame is in progress.
- `done`  output  1  one-cycle pulse when a frame completes.

## Operation
- All outputs are registered.
- Reset values: `mosi`=0, `sck_out`=1, `sync_n`=1, `busy`=0, `done`=0. The pending flag and hold register (macro build) clear, and the FSM enters IDLE.
- A divider counter runs 0..DIV-1. Its terminal count is a *tick*. The counter clears on every state entry.
- FSM states:
  - IDLE: `start`=1 with `busy`=0 latches `data_in` into the shift register. Next: SETUP.
  - SETUP: `sync_n`=0, `mosi`=bit 15, `sck_out`=1, held for DIV cycles. On tick: SHIFT, bit index 0.
  - SHIFT: each bit takes 2·DIV cycles.
    - `sck_out` is low for DIV cycles, then high for DIV cycles.
    - The DAC samples on the falling edge.
    - When `sck_out` rises, `mosi` advances to the next lower bit.
    - After the high half of bit 15 (LSB), go to GAP.
  - GAP: `sync_n`=1, `mosi`=0, `sck_out`=1, held for DIV cycles. On tick: pulse `done`, deassert `busy` in the same cycle, return to IDLE.
- `start` while `busy`=1 is ignored, unless the configuration macro below is defined.
- `start` in the cycle `done` is high is accepted, because `busy`=0 in that cycle.
- `data_in` changing during a frame has no effect on the frame.
- Reset asserted mid-frame forces the reset values immediately, asynchronously. The partial frame is abandoned, with no `done`.

## Timing
- Take edge 0 as the `clk` edge where `start` is accepted.
- Edge 0: `busy`=1, `sync_n`=0, `mosi`=data[15].
- Bit k (k = 0..15):
  - `sck_out` falls at edge DIV·(1+2k).
  - `sck_out` rises at edge DIV·(2+2k).
- `sync_n` rises at edge 33·DIV.
- `done`=1 and `busy`=0 at edge 34·DIV.
- Frame period: 34·DIV cycles. For DIV=4 this is 136 cycles, with 16 falling SCK edges per frame.
- Back-to-back throughput (macro build): one frame per 34·DIV cycles.

## Configuration
- Macro `SPI_DAC_TX_HOLD_EN`.
- Defined: adds a one-deep hold register and a pending flag.
  - `start` while `busy`=1 stores `data_in` and sets pending.
  - A further `start` while pending overwrites the stored word; the last word wins.
  - At GAP exit with pending set: `done` pulses, `busy` stays 1, and the FSM goes directly to SETUP with the held word, clearing pending.
- Undefined: no hold logic; `start` while busy is dropped.

## Test plan
- DIV=4, reset release, `start` with `data_in`=16'hA5C3:
  - `sync_n` low on edge 0.
  - `mosi` sampled at the 16 falling `sck_out` edges reads 1010_0101_1100_0011.
  - `sync_n` high at edge 132.
  - `done` pulses once at edge 136.
- DIV=1, `data_in`=16'hFFFF then 16'h0000 with `start` coincident with `done`:
  - Second frame's `sync_n` low exactly one cycle after `done`.
  - All 16 bits are 0.
- Reset pulled low at edge 40 of a DIV=4 frame:
  - Same cycle: `sync_n`=1, `sck_out`=1, `busy`=0, `mosi`=0.
  - No `done`.
  - Next `start` sends a full, correct frame.
- Macro undefined, `start` with 16'h1234 at edge 10 of a frame carrying 16'h8001:
  - Only 16'h8001 is transmitted.
  - `busy` falls at edge 136.
  - No second frame.
- Macro defined, `start` with 16'h1234 and then 16'h5678 during a 16'hABCD frame:
  - 16'hABCD is sent, then 16'h5678.
  - `done` pulses at edges 136 and 272.
  - `busy` stays high continuously until edge 272.
